avl_rd_arbiter: RTL and testbench

Two-requester arbiter for the 256-bit Avalon-MM read-only memory port. It shares one memory read master between the pixel uploader (requester 0) and a second read client (requester 1), such as a command/LUT loader. Commands pass through with zero added latency. A tag FIFO records the owner of every accepted read, so pipelined `readdatavalid` beats are steered back to the requester that issued them.

---
 rtl/avl_rd_arbiter_if.sv | 27 ++
 rtl/avl_rd_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_avl_rd_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/avl_rd_arbiter_if.sv
// avl_rd_arbiter_if
// One-beat Avalon-MM read port: command (addr/read/waitrequest) plus the
// pipelined response (readdata/readdatavalid/response).
//   master modport : drives addr/read, receives waitrequest and response
//   slave  modport : receives addr/read, drives waitrequest and response
// Parameters: ADDR_W (address width), DATA_W (read data width).
interface avl_rd_arbiter_if #(
    parameter int ADDR_W = 33,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic [1:0]        response;

    modport master (
        output addr, read,
        input  waitrequest, readdata, readdatavalid, response
    );

    modport slave (
        input  addr, read,
        output waitrequest, readdata, readdatavalid, response
    );
endinterface

// File: rtl/avl_rd_arbiter.sv
// avl_rd_arbiter
// Shares one 256-bit Avalon-MM read master between two requesters
// (m0 = pixel uploader, m1 = secondary read client). Commands are muxed
// combinationally; a tag FIFO remembers the owner of each accepted read so
// that readdatavalid beats are steered back with zero added latency.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   m0, m1      : requester ports (slave modport of avl_rd_arbiter_if)
//   s           : memory-side port (master modport of avl_rd_arbiter_if)
//   outstanding : accepted-but-unanswered read count
//   busy        : reads outstanding or any requester asserting read
//   err_orphan  : sticky, a beat arrived while the tag FIFO was empty
//
// Parameters: ADDR_W, DATA_W, MAX_OUTST (power of two, 2..64).
//
// Build option: define AVL_RD_ARB_FIXED_PRIO_EN for fixed priority
// (m0 always wins a tie); default is round-robin between the two.
module avl_rd_arbiter #(
    parameter int ADDR_W    = 33,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    avl_rd_arbiter_if.slave            m0,
    avl_rd_arbiter_if.slave            m1,
    avl_rd_arbiter_if.master           s,
    output logic [$clog2(MAX_OUTST):0] outstanding,
    output logic                       busy,
    output logic                       err_orphan
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Requester views as small arrays so both ports share one code path
    // ------------------------------------------------------------------
    logic [1:0]        req_read;
    logic [ADDR_W-1:0] req_addr [2];
    logic [1:0]        req_wait;
    logic [1:0]        req_rdv;

    assign req_read[0] = m0.read;
    assign req_read[1] = m1.read;
    assign req_addr[0] = m0.addr;
    assign req_addr[1] = m1.addr;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             owner_reg;
    logic             lock_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic             err_orphan_reg;
    logic             tag_mem [MAX_OUTST];
`ifndef AVL_RD_ARB_FIXED_PRIO_EN
    logic             last_served_reg;
`endif

    logic             owner_sel;
    logic             owner_read;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             head_tag;
    logic [DATA_W-1:0] rdata_bcast;

    // Count is registered, so a pop in this cycle does not free a slot for
    // a push until the next cycle; this keeps fifo_full off the response path.
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTST));
    assign fifo_empty = (count_reg == '0);

    // ------------------------------------------------------------------
    // Owner selection. While a stalled command is pending (lock_reg) the
    // grant is frozen so addr/read stay stable until accepted.
    // ------------------------------------------------------------------
    always_comb begin
        owner_sel = owner_reg;
        if (!lock_reg) begin
            if (req_read[0] && req_read[1]) begin
`ifdef AVL_RD_ARB_FIXED_PRIO_EN
                owner_sel = 1'b0;
`else
                owner_sel = ~last_served_reg;
`endif
            end else if (req_read[1]) begin
                owner_sel = 1'b1;
            end else begin
                owner_sel = 1'b0;
            end
        end
    end

    assign owner_read = req_read[owner_sel];

    // Address is forced to zero when the owner is not requesting, so the
    // bus is quiet when idle.
    assign s.addr = owner_read ? req_addr[owner_sel] : '0;
    assign s.read = owner_read & ~fifo_full;

    assign accept   = s.read & ~s.waitrequest;
    assign push     = accept;
    assign pop      = s.readdatavalid & ~fifo_empty;
    assign head_tag = tag_mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Per-requester waitrequest and readdatavalid
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_wait[gi] = (owner_sel == 1'(gi)) ? (s.waitrequest | fifo_full) : 1'b1;
            assign req_rdv[gi]  = pop & (head_tag == 1'(gi));
        end
    endgenerate

    assign rdata_bcast = s.readdata;

    assign m0.waitrequest   = req_wait[0];
    assign m1.waitrequest   = req_wait[1];
    assign m0.readdatavalid = req_rdv[0];
    assign m1.readdatavalid = req_rdv[1];
    assign m0.readdata      = rdata_bcast;
    assign m1.readdata      = rdata_bcast;
    assign m0.response      = s.response;
    assign m1.response      = s.response;

    // ------------------------------------------------------------------
    // Tag storage: no reset needed, validity is tracked by count/pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= owner_sel;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg      <= 1'b0;
            lock_reg       <= 1'b0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            err_orphan_reg <= 1'b0;
        end else begin
            owner_reg <= owner_sel;

            if (accept) begin
                lock_reg <= 1'b0;
            end else if (s.read && s.waitrequest) begin
                lock_reg <= 1'b1;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (s.readdatavalid && fifo_empty) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

`ifndef AVL_RD_ARB_FIXED_PRIO_EN
    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served_reg <= 1'b1;
        end else if (accept) begin
            last_served_reg <= owner_sel;
        end
    end
`endif

    assign outstanding = count_reg;
    assign busy        = (count_reg != '0) | req_read[0] | req_read[1];
    assign err_orphan  = err_orphan_reg;

endmodule

// File: tb/tb_avl_rd_arbiter.sv
// tb_avl_rd_arbiter
// Directed bench for avl_rd_arbiter. Each step drives one cycle of inputs,
// checks the combinational command/response outputs, then checks the
// registered status after the clock edge. Expected owners are pushed to a
// scoreboard queue on acceptance and popped when a beat is delivered.
module tb_avl_rd_arbiter;
    localparam int ADDR_W    = 33;
    localparam int DATA_W    = 256;
    localparam int MAX_OUTST = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [$clog2(MAX_OUTST):0] outstanding;
    logic busy;
    logic err_orphan;

    avl_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    avl_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    avl_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    avl_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if.slave),
        .m1          (m1_if.slave),
        .s           (s_if.master),
        .outstanding (outstanding),
        .busy        (busy),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic exp_orphan = 1'b0;
    int sb[$];

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_if.read = 1'b0; m0_if.addr = '0;
        m1_if.read = 1'b0; m1_if.addr = '0;
        s_if.waitrequest = 1'b0; s_if.readdatavalid = 1'b0;
        s_if.readdata = '0; s_if.response = 2'b00;
    endtask

    // Reset with all inputs idle; checks the reset-state outputs.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 0;
        exp_orphan = 1'b0;
        @(posedge clk); #1;
        chk("rst_s_read", s_if.read, 1'b0);
        chk("rst_s_addr", s_if.addr, '0);
        chk("rst_m0_rdv", m0_if.readdatavalid, 1'b0);
        chk("rst_m1_rdv", m1_if.readdatavalid, 1'b0);
        chk("rst_outstanding", outstanding, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_orphan", err_orphan, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One cycle. own: expected owner (0/1); exp_rd: expected s_read.
    task automatic step(input logic r0, input logic [ADDR_W-1:0] a0,
                        input logic r1, input logic [ADDR_W-1:0] a1,
                        input logic wr, input logic rdv,
                        input int own, input logic exp_rd);
        logic [DATA_W-1:0] d;
        logic [1:0] rsp;
        int exp_tag;
        d = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        rsp = 2'($urandom_range(3));
        m0_if.read = r0; m0_if.addr = a0;
        m1_if.read = r1; m1_if.addr = a1;
        s_if.waitrequest = wr; s_if.readdatavalid = rdv;
        s_if.readdata = d; s_if.response = rsp;
        #1;
        chk("s_read", s_if.read, exp_rd);
        if (exp_rd) chk("s_addr", s_if.addr, (own == 1) ? a1 : a0);
        chk("owner_wait", (own == 1) ? m1_if.waitrequest : m0_if.waitrequest,
            wr | (exp_cnt == MAX_OUTST));
        chk("other_wait", (own == 1) ? m0_if.waitrequest : m1_if.waitrequest, 1'b1);
        chk("busy", busy, (exp_cnt != 0) || r0 || r1);
        if (rdv) begin
            if (sb.size() > 0) begin
                exp_tag = sb.pop_front();
                exp_cnt--;
            end else begin
                exp_tag = -1;
                exp_orphan = 1'b1;
            end
            chk("m0_rdv", m0_if.readdatavalid, exp_tag == 0);
            chk("m1_rdv", m1_if.readdatavalid, exp_tag == 1);
            chk("m0_rdata", m0_if.readdata, d);
            chk("m1_rdata", m1_if.readdata, d);
            chk("m0_resp", m0_if.response, rsp);
            chk("m1_resp", m1_if.response, rsp);
        end else begin
            chk("m0_rdv_idle", m0_if.readdatavalid, 1'b0);
            chk("m1_rdv_idle", m1_if.readdatavalid, 1'b0);
        end
        if (exp_rd && !wr) begin
            sb.push_back(own);
            exp_cnt++;
            $display("accept: owner %0d addr %0h outstanding-> %0d", own, (own == 1) ? a1 : a0, exp_cnt);
        end
        @(posedge clk); #1;
        chk("outstanding", outstanding, exp_cnt);
        chk("err_orphan", err_orphan, exp_orphan);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_own [4];
`ifdef AVL_RD_ARB_FIXED_PRIO_EN
        rr_own = '{0, 0, 0, 0};
`else
        rr_own = '{0, 1, 0, 1};
`endif
        idle_inputs();

        // Single requester, back-to-back, answers two cycles later
        do_reset();
        step(1, 33'h100, 0, 0, 0, 0, 0, 1);
        step(1, 33'h120, 0, 0, 0, 0, 0, 1);
        step(1, 33'h140, 0, 0, 0, 1, 0, 1);
        step(0, 0,       0, 0, 0, 1, 0, 0);
        step(0, 0,       0, 0, 0, 1, 0, 0);

        // Simultaneous requests: round-robin grant order
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 33'h200, 1, 33'h300, 0, 0, rr_own[k], 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 0, 0);

        // Stall lock: grant frozen on m0 while the slave stalls
        do_reset();
        step(1, 33'h3F0, 0, 0,       0, 0, 0, 1);
        step(1, 33'h400, 0, 0,       1, 0, 0, 1);
        step(1, 33'h400, 1, 33'h500, 1, 0, 0, 1);
        step(1, 33'h400, 1, 33'h500, 1, 0, 0, 1);
        step(1, 33'h400, 1, 33'h500, 0, 0, 0, 1);
        step(0, 0,       1, 33'h500, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, 0, 0);

        // FIFO full: ninth request blocked until a beat returns
        do_reset();
        for (int k = 0; k < MAX_OUTST; k++) step(1, 33'(33'h1000 + k * 32), 0, 0, 0, 0, 0, 1);
        step(1, 33'h1100, 0, 0, 0, 0, 0, 0);
        step(1, 33'h1100, 0, 0, 0, 1, 0, 0);
        step(1, 33'h1100, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < MAX_OUTST; k++) step(0, 0, 0, 0, 0, 1, 0, 0);

        // Same-cycle accept and beat at count 4
        do_reset();
        step(1, 33'h600, 0, 0,       0, 0, 0, 1);
        step(0, 0,       1, 33'h700, 0, 0, 1, 1);
        step(1, 33'h620, 0, 0,       0, 0, 0, 1);
        step(0, 0,       1, 33'h720, 0, 0, 1, 1);
        step(1, 33'h640, 0, 0,       0, 1, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 0, 0);

        // Reset with reads in flight, then an orphan beat
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 1, 33'(33'h800 + k * 32), 0, 0, 1, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 33'h900, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
